// File: rtl/spi_target_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_target_pkg
// Purpose  : Shared state encoding and command-word layout for spi_reg_target.
// Revision : 1.0 - initial release
// ============================================================================
package spi_target_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CMD     = 3'd1,
    RD_LOAD = 3'd2,
    RD_DATA = 3'd3,
    WR_DATA = 3'd4,
    DONE    = 3'd5
  } state_e;

  localparam int CMD_RW_BIT = 15;
  localparam int CMD_BITS   = 16;

endpackage
`default_nettype wire

// File: rtl/spi_sync_edge.sv
`default_nettype none
// ============================================================================
// Module   : spi_sync_edge
// Purpose  : N-stage synchronizer with single-cycle rise/fall pulses.
// Revision : 1.0 - initial release
// ============================================================================
module spi_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
    prev_d = sync_q[STAGES-1];
  end

  // Reset to the idle level so leaving reset never fakes an edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign sync = sync_q[STAGES-1];
  assign rise = sync & ~prev_q;
  assign fall = ~sync & prev_q;

endmodule
`default_nettype wire

// File: rtl/spi_reg_target.sv
`default_nettype none
// ============================================================================
// Module   : spi_reg_target
// Purpose  : Mode-0 SPI target bridging a 16-bit command + data frame onto the
//            register bus. Optional SPI_TARGET_FRAME_ERR_EN adds frame_error.
// Revision : 1.0 - initial release
// ============================================================================
module spi_reg_target
  import spi_target_pkg::*;
#(
  parameter int ADDR_W      = 15,
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              spi_sclk,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data_out,
  input  logic [DATA_W-1:0] data_in,
  output logic              read,
  output logic              write
`ifdef SPI_TARGET_FRAME_ERR_EN
  ,
  output logic              frame_error
`endif
);

  localparam int         RX_W         = (DATA_W > CMD_BITS) ? DATA_W : CMD_BITS;
  localparam logic [4:0] c_cmd_last   = 5'(CMD_BITS - 1);
  localparam logic [4:0] c_frame_last = 5'(CMD_BITS + DATA_W - 1);

  logic sclk_level_unused, sclk_rise, sclk_fall;
  logic cs_n_s, cs_rise, cs_fall;
  logic mosi_s;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
    .clk(clk), .reset_n(reset_n), .d(spi_sclk),
    .sync(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .clk(clk), .reset_n(reset_n), .d(spi_cs_n),
    .sync(cs_n_s), .rise(cs_rise), .fall(cs_fall)
  );

  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  state_e                 state_q, state_d;
  logic [4:0]             bit_cnt_q, bit_cnt_d;
  logic [RX_W-1:0]        rx_q, rx_d, rx_shifted;
  logic [DATA_W-1:0]      tx_q, tx_d;
  logic                   miso_q, miso_d;
  logic                   oe_q, oe_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [DATA_W-1:0]      dout_q, dout_d;
  logic                   read_q, read_d;
  logic                   write_q, write_d;
  logic                   ferr_q, ferr_d;

  assign mosi_s     = mosi_sync_q[SYNC_STAGES-1];
  assign rx_shifted = {rx_q[RX_W-2:0], mosi_s};

  always_comb begin
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    miso_d      = miso_q;
    oe_d        = ~cs_n_s;
    addr_d      = addr_q;
    dout_d      = dout_q;
    read_d      = 1'b0;
    write_d     = 1'b0;
    ferr_d      = ferr_q;

    case (state_q)
      IDLE: begin
        miso_d = 1'b0;
        if (cs_fall) begin
          bit_cnt_d = '0;
          state_d   = CMD;
        end
      end
      CMD: begin
        miso_d = 1'b0;
        if (sclk_rise) begin
          rx_d      = rx_shifted;
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == c_cmd_last) begin
            addr_d = rx_shifted[ADDR_W-1:0];
            if (rx_shifted[CMD_RW_BIT]) begin
              read_d  = 1'b1;
              state_d = RD_LOAD;
            end else begin
              state_d = WR_DATA;
            end
          end
        end
      end
      // Wait out the strobe cycle so data_in is taken one clk after read
      RD_LOAD: begin
        if (!read_q) begin
          tx_d    = data_in;
          state_d = RD_DATA;
        end
      end
      RD_DATA: begin
        if (sclk_fall) begin
          miso_d = tx_q[DATA_W-1];
          tx_d   = {tx_q[DATA_W-2:0], 1'b0};
        end
        if (sclk_rise) begin
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == c_frame_last) state_d = DONE;
        end
      end
      WR_DATA: begin
        if (sclk_rise) begin
          rx_d      = rx_shifted;
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == c_frame_last) begin
            dout_d  = rx_shifted[DATA_W-1:0];
            write_d = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        miso_d = 1'b0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Deselect wins over everything and ends the frame
    if (cs_rise) begin
      state_d = IDLE;
      read_d  = 1'b0;
      write_d = 1'b0;
      miso_d  = 1'b0;
`ifdef SPI_TARGET_FRAME_ERR_EN
      if (state_q inside {CMD, RD_LOAD, RD_DATA, WR_DATA}) ferr_d = 1'b1;
      else if (state_q == DONE)                              ferr_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mosi_sync_q <= '0;
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      miso_q      <= 1'b0;
      oe_q        <= 1'b0;
      addr_q      <= '0;
      dout_q      <= '0;
      read_q      <= 1'b0;
      write_q     <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      mosi_sync_q <= mosi_sync_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      miso_q      <= miso_d;
      oe_q        <= oe_d;
      addr_q      <= addr_d;
      dout_q      <= dout_d;
      read_q      <= read_d;
      write_q     <= write_d;
      ferr_q      <= ferr_d;
    end
  end

  assign spi_miso    = miso_q;
  assign spi_miso_oe = oe_q;
  assign address     = addr_q;
  assign data_out    = dout_q;
  assign read        = read_q;
  assign write       = write_q;
`ifdef SPI_TARGET_FRAME_ERR_EN
  assign frame_error = ferr_q;
`else
  logic ferr_unused;
  assign ferr_unused = ferr_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_reg_target.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_reg_target
// Purpose  : Self-checking bench for spi_reg_target (table + random frames).
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_reg_target;

  localparam int HALF = 5;  // clk cycles per SCLK half period

  logic        clk = 1'b0;
  logic        reset_n, spi_sclk, spi_cs_n, spi_mosi;
  logic        spi_miso, spi_miso_oe, read, write;
  logic [14:0] address;
  logic [15:0] data_out, data_in;
`ifdef SPI_TARGET_FRAME_ERR_EN
  logic        frame_error;
`endif

  always #5 clk = ~clk;

  spi_reg_target dut (
    .clk(clk), .reset_n(reset_n),
    .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .address(address), .data_out(data_out), .data_in(data_in),
    .read(read), .write(write)
`ifdef SPI_TARGET_FRAME_ERR_EN
    , .frame_error(frame_error)
`endif
  );

  int          checks = 0;
  int          errors = 0;
  int          wr_cnt = 0, rd_cnt = 0, both_cnt = 0;
  logic [14:0] wr_addr = '0, rd_addr = '0;
  logic [15:0] wr_data = '0;
  logic [15:0] ret_val;
  int          rst_wr0, rst_rd0;
  logic [15:0] model [logic [14:0]];

  typedef struct {
    logic [15:0] cmd;
    logic [15:0] wd;
    int          nbits;
    logic [15:0] ret;
    int          exp_wr;
    int          exp_rd;
    logic [14:0] exp_addr;
    logic [15:0] exp_data;
    logic        exp_ferr;
  } vec_t;

  // Bus strobe observer
  always @(negedge clk) begin
    if (write) begin
      wr_cnt  <= wr_cnt + 1;
      wr_addr <= address;
      wr_data <= data_out;
    end
    if (read) begin
      rd_cnt  <= rd_cnt + 1;
      rd_addr <= address;
    end
    if (read && write) both_cnt <= both_cnt + 1;
  end

  // Register-bus responder: junk in the strobe cycle, real data one clk later
  initial begin
    forever begin
      @(posedge clk); #1;
      if (read === 1'b1) begin
        data_in = ~ret_val;
        @(posedge clk); #1;
        data_in = ret_val;
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] bus_value(input logic [14:0] a);
    if (model.exists(a)) return model[a];
    return 16'(a) ^ 16'hC33C;
  endfunction

  task automatic xfer(input logic [15:0] cmd, input logic [15:0] wd, input int nbits,
                      input int rst_at, output logic [15:0] rd);
    logic [31:0] word;
    word     = {cmd, wd};
    rd       = '0;
    spi_cs_n = 1'b0;
    tick(HALF);
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = (i < 32) ? word[31-i] : 1'($urandom);
      tick(HALF);
      spi_sclk = 1'b1;
      if (i >= 16 && i < 32) rd[31-i] = spi_miso;
      if (i == 0 && rst_at < 0) chk("miso_oe_selected", 32'(spi_miso_oe), 32'd1);
      tick(HALF);
      spi_sclk = 1'b0;
      if (i == rst_at) begin
        reset_n = 1'b0;
        #1;
        chk("rst_mid_miso", 32'(spi_miso), 32'd0);
        chk("rst_mid_oe", 32'(spi_miso_oe), 32'd0);
        chk("rst_mid_addr", 32'(address), 32'd0);
        chk("rst_mid_dout", 32'(data_out), 32'd0);
        chk("rst_mid_read", 32'(read), 32'd0);
        chk("rst_mid_write", 32'(write), 32'd0);
        tick(2);
        reset_n = 1'b1;
        rst_wr0 = wr_cnt;
        rst_rd0 = rd_cnt;
      end
    end
    tick(HALF);
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    tick(2 * HALF);
  endtask

  // Apply one frame and judge it from the frame-level rules
  task automatic run_frame(input string tag, input logic [15:0] cmd, input logic [15:0] wd,
                           input int nbits, input logic [15:0] ret, input logic [15:0] exp_rdata);
    int          w0, r0, exp_wr, exp_rd;
    logic [15:0] rd;
    logic        is_rd;
    is_rd   = cmd[15];
    ret_val = ret;
    w0      = wr_cnt;
    r0      = rd_cnt;
    xfer(cmd, wd, nbits, -1, rd);
    tick(2);
    exp_wr = (!is_rd && nbits >= 32) ? 1 : 0;
    exp_rd = (is_rd && nbits >= 16) ? 1 : 0;
    chk({tag, "_write_pulses"}, 32'(wr_cnt - w0), 32'(exp_wr));
    chk({tag, "_read_pulses"}, 32'(rd_cnt - r0), 32'(exp_rd));
    if (exp_wr == 1) begin
      chk({tag, "_wr_addr"}, 32'(wr_addr), 32'(cmd[14:0]));
      chk({tag, "_wr_data"}, 32'(wr_data), 32'(wd));
      model[cmd[14:0]] = wd;
    end
    if (exp_rd == 1) chk({tag, "_rd_addr"}, 32'(rd_addr), 32'(cmd[14:0]));
    if (is_rd && nbits >= 32) chk({tag, "_miso_data"}, 32'(rd), 32'(exp_rdata));
    chk({tag, "_oe_idle"}, 32'(spi_miso_oe), 32'd0);
`ifdef SPI_TARGET_FRAME_ERR_EN
    chk({tag, "_frame_error"}, 32'(frame_error), 32'(nbits < 32));
`endif
  endtask

  initial begin
    vec_t        tbl [6];
    logic [15:0] rd;
    logic [14:0] a;
    logic [15:0] cmd, wd;
    int          nbits, sel, w0, r0;

    reset_n  = 1'b0;
    spi_sclk = 1'b0;
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    data_in  = '0;
    ret_val  = '0;
    tick(3);
    reset_n = 1'b1;
    tick(3);
    chk("reset_miso", 32'(spi_miso), 32'd0);
    chk("reset_oe", 32'(spi_miso_oe), 32'd0);
    chk("reset_addr", 32'(address), 32'd0);
    chk("reset_dout", 32'(data_out), 32'd0);
    chk("reset_read", 32'(read), 32'd0);
    chk("reset_write", 32'(write), 32'd0);
`ifdef SPI_TARGET_FRAME_ERR_EN
    chk("reset_frame_error", 32'(frame_error), 32'd0);
`endif

    //          cmd       wd        bits ret       wr rd addr      data      ferr
    tbl[0] = '{16'h0012, 16'hBEEF, 32, 16'h0000, 1, 0, 15'h0012, 16'hBEEF, 1'b0};
    tbl[1] = '{16'h8034, 16'h0000, 32, 16'hA5C3, 0, 1, 15'h0034, 16'hA5C3, 1'b0};
    tbl[2] = '{16'h0001, 16'h1234, 24, 16'h0000, 0, 0, 15'h0000, 16'h0000, 1'b1};
    tbl[3] = '{16'h7FFF, 16'h1357, 32, 16'h0000, 1, 0, 15'h7FFF, 16'h1357, 1'b0};
    tbl[4] = '{16'hFFFF, 16'h0000, 32, 16'h1357, 0, 1, 15'h7FFF, 16'h1357, 1'b0};
    tbl[5] = '{16'h0042, 16'hC0DE, 40, 16'h0000, 1, 0, 15'h0042, 16'hC0DE, 1'b0};

    for (int k = 0; k < 6; k++) begin
      ret_val = tbl[k].ret;
      w0 = wr_cnt;
      r0 = rd_cnt;
      xfer(tbl[k].cmd, tbl[k].wd, tbl[k].nbits, -1, rd);
      tick(2);
      chk($sformatf("vec%0d_write_pulses", k), 32'(wr_cnt - w0), 32'(tbl[k].exp_wr));
      chk($sformatf("vec%0d_read_pulses", k), 32'(rd_cnt - r0), 32'(tbl[k].exp_rd));
      if (tbl[k].exp_wr == 1) begin
        chk($sformatf("vec%0d_wr_addr", k), 32'(wr_addr), 32'(tbl[k].exp_addr));
        chk($sformatf("vec%0d_wr_data", k), 32'(wr_data), 32'(tbl[k].exp_data));
        model[tbl[k].cmd[14:0]] = tbl[k].wd;
      end
      if (tbl[k].exp_rd == 1) begin
        chk($sformatf("vec%0d_rd_addr", k), 32'(rd_addr), 32'(tbl[k].exp_addr));
        chk($sformatf("vec%0d_miso_data", k), 32'(rd), 32'(tbl[k].exp_data));
      end
      chk($sformatf("vec%0d_oe_idle", k), 32'(spi_miso_oe), 32'd0);
`ifdef SPI_TARGET_FRAME_ERR_EN
      chk($sformatf("vec%0d_frame_error", k), 32'(frame_error), 32'(tbl[k].exp_ferr));
`endif
    end

    // Reset during read data bit 5; the remainder of that frame is lost
    ret_val = 16'hA5C3;
    xfer(16'h8034, 16'h0000, 32, 21, rd);
    tick(2);
    chk("post_rst_write_pulses", 32'(wr_cnt - rst_wr0), 32'd0);
    chk("post_rst_read_pulses", 32'(rd_cnt - rst_rd0), 32'd0);
    run_frame("post_rst_wr", 16'h0055, 16'h2468, 32, 16'h0000, 16'h0000);
    run_frame("post_rst_rd", 16'h8055, 16'h0000, 32, bus_value(15'h0055), 16'h2468);

    // Random frames against the frame-level reference model
    for (int n = 0; n < 24; n++) begin
      sel = $urandom_range(0, 2);
      a   = (sel == 0) ? 15'h0000 : (sel == 1) ? 15'h7FFF : 15'(15'h0100 + $urandom_range(0, 7));
      cmd = {1'($urandom_range(0, 1)), a};
      wd  = 16'($urandom);
      sel = $urandom_range(0, 9);
      nbits = (sel < 7) ? 32 : (sel < 9) ? $urandom_range(33, 40) : $urandom_range(1, 31);
      run_frame($sformatf("rand%0d", n), cmd, wd, nbits, bus_value(a), bus_value(a));
    end

    chk("read_write_overlap", 32'(both_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
